// File: rtl/exe_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit, BPC bits per cycle; done and hi/lo valid WIDTH/BPC+2 cycles after start.
// Holds upstream with stall_out from the accepting cycle through FINISH; flush or reset aborts without writing hi/lo.
module exe_muldiv #(
   parameter int WIDTH = 32,
   parameter int BPC   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             stall_out,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int N  = WIDTH / BPC;
   localparam int CW = $clog2(N + 1);

   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;

   typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH:0]   work_hi_q, work_hi_d;
   logic [WIDTH-1:0] work_lo_q, work_lo_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic             is_div_q, is_div_d;
   logic             neg_q, neg_d;
   logic             rneg_q, rneg_d;
   logic             dz_q, dz_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             done_q, done_d;
   logic             div_zero_q, div_zero_d;

   logic             is_md, is_sgn, op_div, a_neg, b_neg, accept;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   step_hi;
   logic [WIDTH-1:0] step_lo;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   assign is_md  = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
   assign is_sgn = (op == OP_MULT) || (op == OP_DIV);
   assign op_div = (op == OP_DIV) || (op == OP_DIVU);
   assign a_neg  = is_sgn && src_a[WIDTH-1];
   assign b_neg  = is_sgn && src_b[WIDTH-1];
   assign a_mag  = a_neg ? -src_a : src_a;
   assign b_mag  = b_neg ? -src_b : src_b;
   assign accept = (state_q == IDLE) && start && !flush && is_md;

   // Mul: work_hi accumulates, multiplier shifts out of work_lo. Div: work_hi is the partial remainder.
   always_comb begin
      step_hi = work_hi_q;
      step_lo = work_lo_q;
      for (int i = 0; i < BPC; i++) begin
         if (is_div_q) begin
            step_hi = {step_hi[WIDTH-1:0], step_lo[WIDTH-1]};
            step_lo = {step_lo[WIDTH-2:0], 1'b0};
            if (step_hi >= {1'b0, opb_q}) begin
               step_hi    = step_hi - {1'b0, opb_q};
               step_lo[0] = 1'b1;
            end
         end else begin
            if (step_lo[0]) begin
               step_hi = step_hi + {1'b0, opb_q};
            end
            step_lo = {step_hi[0], step_lo[WIDTH-1:1]};
            step_hi = {1'b0, step_hi[WIDTH:1]};
         end
      end
   end

   assign prod     = {work_hi_q[WIDTH-1:0], work_lo_q};
   assign prod_fix = neg_q ? -prod : prod;
   assign quo_fix  = neg_q ? -work_lo_q : work_lo_q;
   assign rem_fix  = rneg_q ? -work_hi_q[WIDTH-1:0] : work_hi_q[WIDTH-1:0];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      work_hi_d  = work_hi_q;
      work_lo_d  = work_lo_q;
      opb_d      = opb_q;
      is_div_d   = is_div_q;
      neg_d      = neg_q;
      rneg_d     = rneg_q;
      dz_d       = dz_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      done_d     = 1'b0;
      div_zero_d = 1'b0;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  state_d   = CALC;
                  cnt_d     = CW'(N);
                  is_div_d  = op_div;
                  dz_d      = op_div && (src_b == '0);
                  neg_d     = a_neg ^ b_neg;
                  rneg_d    = op_div && a_neg;
                  work_hi_d = '0;
                  work_lo_d = op_div ? a_mag : b_mag;
                  opb_d     = op_div ? b_mag : a_mag;
               end else if (start && (op == OP_MTHI)) begin
                  hi_d = src_a;
               end else if (start && (op == OP_MTLO)) begin
                  lo_d = src_a;
               end
            end
            CALC: begin
               work_hi_d = step_hi;
               work_lo_d = step_lo;
               cnt_d     = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = FINISH;
               end
            end
            FINISH: begin
               state_d = IDLE;
               done_d  = 1'b1;
               if (!is_div_q) begin
                  {hi_d, lo_d} = prod_fix;
               end else if (dz_q) begin
                  div_zero_d = 1'b1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         work_hi_q  <= '0;
         work_lo_q  <= '0;
         opb_q      <= '0;
         is_div_q   <= 1'b0;
         neg_q      <= 1'b0;
         rneg_q     <= 1'b0;
         dz_q       <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         done_q     <= 1'b0;
         div_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         work_hi_q  <= work_hi_d;
         work_lo_q  <= work_lo_d;
         opb_q      <= opb_d;
         is_div_q   <= is_div_d;
         neg_q      <= neg_d;
         rneg_q     <= rneg_d;
         dz_q       <= dz_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         done_q     <= done_d;
         div_zero_q <= div_zero_d;
      end
   end

   // Gated by rst so the hold request drops the instant reset asserts.
   assign stall_out = rst && !flush && !done_q && ((state_q != IDLE) || accept);
   assign busy      = (state_q != IDLE);
   assign done      = done_q;
   assign div_zero  = div_zero_q;
   assign hi        = hi_q;
   assign lo        = lo_q;
endmodule

// File: tb/tb_exe_muldiv.sv
// Bench for exe_muldiv: vector table plus scoreboard, with flush, reset and BPC=4 sequences.
module tb_exe_muldiv;
   localparam int W = 32;
   localparam logic [2:0] OP_MULT  = 3'b001;
   localparam logic [2:0] OP_MULTU = 3'b010;
   localparam logic [2:0] OP_DIV   = 3'b011;
   localparam logic [2:0] OP_DIVU  = 3'b100;
   localparam logic [2:0] OP_MTHI  = 3'b101;
   localparam logic [2:0] OP_MTLO  = 3'b110;
   localparam int NV = 14;

   logic         clk, rst, start, flush;
   logic [2:0]   op;
   logic [W-1:0] src_a, src_b;
   logic         stall_out, busy, done, div_zero;
   logic [W-1:0] hi, lo;

   logic         start4;
   logic [2:0]   op4;
   logic [W-1:0] a4, b4;
   logic         stall4, busy4, done4, dz4;
   logic [W-1:0] hi4, lo4;

   exe_muldiv #(.WIDTH(W), .BPC(1)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
      .flush(flush), .stall_out(stall_out), .busy(busy), .done(done),
      .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   exe_muldiv #(.WIDTH(W), .BPC(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .op(op4), .src_a(a4), .src_b(b4),
      .flush(1'b0), .stall_out(stall4), .busy(busy4), .done(done4),
      .div_zero(dz4), .hi(hi4), .lo(lo4)
   );

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] eh;
      logic [W-1:0] el;
      logic         ez;
   } vec_t;

   typedef struct {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         dz;
   } exp_t;

   exp_t         sb_q[$];
   vec_t         vt[NV];
   int           total = 0;
   int           bad = 0;
   logic [W-1:0] m_hi, m_lo;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference built on the simulator's own signed/unsigned arithmetic.
   function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [W-1:0] ph, input logic [W-1:0] pl);
      exp_t        e;
      longint      sa, sb, sp;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      e.hi = ph;
      e.lo = pl;
      e.dz = 1'b0;
      case (o)
         OP_MULT:  begin sp = sa * sb; {e.hi, e.lo} = sp; end
         OP_MULTU: begin up = {32'd0, a} * {32'd0, b}; {e.hi, e.lo} = up; end
         OP_DIV: begin
            if (b == '0) e.dz = 1'b1;
            else begin e.lo = 32'(sa / sb); e.hi = 32'(sa % sb); end
         end
         OP_DIVU: begin
            if (b == '0) e.dz = 1'b1;
            else begin e.lo = a / b; e.hi = a % b; end
         end
         default: ;
      endcase
      return e;
   endfunction

   // Entered just after a rising edge; returns just after the next one.
   task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(negedge clk);
      chk("stall_accept", 64'(stall_out), 64'(1));
      chk("idle_before_start", 64'(busy), 64'(0));
      @(posedge clk); #1;
      start = 1'b0; op = 3'b000; src_a = '0; src_b = '0;
   endtask

   task automatic mt(input logic [2:0] o, input logic [W-1:0] v);
      start = 1'b1; op = o; src_a = v;
      @(negedge clk);
      chk("mt_no_stall", 64'(stall_out), 64'(0));
      @(posedge clk); #1;
      start = 1'b0; op = 3'b000; src_a = '0;
      if (o == OP_MTHI) m_hi = v; else m_lo = v;
      @(negedge clk);
      chk("mt_hi", 64'(hi), 64'(m_hi));
      chk("mt_lo", 64'(lo), 64'(m_lo));
      chk("mt_no_done", 64'(done), 64'(0));
      @(posedge clk); #1;
   endtask

   // lat0 is the cycle index (relative to start) the caller is currently in.
   task automatic wait_done(input int lat0, input int lat_exp);
      int   lat;
      bit   seen, stall_ok;
      exp_t e;
      lat = lat0; seen = 1'b0; stall_ok = 1'b1;
      while (!seen && lat < lat0 + 200) begin
         @(negedge clk);
         if (done) seen = 1'b1;
         else begin
            if (!stall_out || !busy) stall_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
         end
      end
      chk("done_seen", 64'(seen), 64'(1));
      if (seen) begin
         chk("latency", 64'(lat), 64'(lat_exp));
         chk("stall_busy_during_op", 64'(stall_ok), 64'(1));
         chk("stall_at_done", 64'(stall_out), 64'(0));
         if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard: done seen with no expected result queued");
         end else begin
            e = sb_q.pop_front();
            chk("hi", 64'(hi), 64'(e.hi));
            chk("lo", 64'(lo), 64'(e.lo));
            chk("div_zero", 64'(div_zero), 64'(e.dz));
            m_hi = e.hi; m_lo = e.lo;
         end
         @(posedge clk); #1;
         @(negedge clk);
         chk("done_pulse_width", 64'(done), 64'(0));
         chk("div_zero_pulse_width", 64'(div_zero), 64'(0));
         @(posedge clk); #1;
      end
   endtask

   initial begin
      exp_t         e;
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      bit           quiet;
      int           lat;
      bit           seen;

      vt[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0};
      vt[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0};
      vt[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vt[3]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vt[4]  = '{OP_DIVU,  32'h00000007, 32'h00000000, 32'h11111111, 32'h22222222, 1'b1};
      vt[5]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vt[6]  = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
      vt[7]  = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0};
      vt[8]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
      vt[9]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vt[10] = '{OP_DIV,   32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0};
      vt[11] = '{OP_DIV,   32'h00000005, 32'h00000000, 32'h11111111, 32'h22222222, 1'b1};
      vt[12] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
      vt[13] = '{OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0};

      // Reset state, with a valid request presented to prove stall_out is gated.
      rst = 1'b0; flush = 1'b0; start = 1'b1; op = OP_MULT; src_a = '1; src_b = 32'd2;
      start4 = 1'b0; op4 = 3'b000; a4 = '0; b4 = '0;
      m_hi = '0; m_lo = '0;
      #12;
      chk("rst_hi", 64'(hi), 64'(0));
      chk("rst_lo", 64'(lo), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_div_zero", 64'(div_zero), 64'(0));
      chk("rst_stall", 64'(stall_out), 64'(0));
      start = 1'b0; op = 3'b000; src_a = '0; src_b = '0;
      @(posedge clk); #1;
      rst = 1'b1;

      // First start right after reset release.
      sb_q.push_back(model(OP_MULTU, 32'h00012345, 32'h00000100, m_hi, m_lo));
      issue(OP_MULTU, 32'h00012345, 32'h00000100);
      wait_done(1, 34);

      for (int i = 0; i < NV; i++) begin
         mt(OP_MTHI, 32'h11111111);
         mt(OP_MTLO, 32'h22222222);
         e.hi = vt[i].eh; e.lo = vt[i].el; e.dz = vt[i].ez;
         sb_q.push_back(e);
         issue(vt[i].op, vt[i].a, vt[i].b);
         wait_done(1, 34);
      end

      for (int i = 0; i < 8; i++) begin
         ro = 3'($urandom_range(1, 4));
         ra = $urandom;
         rb = (i == 5) ? 32'd0 : ((i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
         if (i == 3) ra = 32'h80000000;
         sb_q.push_back(model(ro, ra, rb, m_hi, m_lo));
         issue(ro, ra, rb);
         wait_done(1, 34);
      end

      // Requests while busy are ignored, including moves.
      sb_q.push_back(model(OP_DIVU, 32'd1000, 32'd7, m_hi, m_lo));
      issue(OP_DIVU, 32'd1000, 32'd7);
      repeat (2) begin @(posedge clk); #1; end
      start = 1'b1; op = OP_MTHI; src_a = 32'hDEADBEEF;
      @(posedge clk); #1;
      op = OP_MULT; src_b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; op = 3'b000; src_a = '0; src_b = '0;
      wait_done(5, 34);

      // Flush mid-divide, then a fresh MULTU two cycles later.
      issue(OP_DIVU, 32'd100, 32'd3);
      repeat (9) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(negedge clk);
      chk("flush_stall_low", 64'(stall_out), 64'(0));
      chk("flush_busy_before", 64'(busy), 64'(1));
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("flush_busy_after", 64'(busy), 64'(0));
      chk("flush_no_done", 64'(done), 64'(0));
      chk("flush_hi_kept", 64'(hi), 64'(m_hi));
      chk("flush_lo_kept", 64'(lo), 64'(m_lo));
      @(posedge clk); #1;
      sb_q.push_back(model(OP_MULTU, 32'hFFFFFFFF, 32'h00000002, m_hi, m_lo));
      issue(OP_MULTU, 32'hFFFFFFFF, 32'h00000002);
      wait_done(13, 46);

      // Flush together with start: nothing accepted, moves included.
      start = 1'b1; op = OP_MTHI; src_a = 32'hCAFEF00D; flush = 1'b1;
      @(posedge clk); #1;
      op = OP_MULT; src_a = 32'd9; src_b = 32'd9;
      @(negedge clk);
      chk("flush_start_stall", 64'(stall_out), 64'(0));
      chk("flush_mthi_blocked", 64'(hi), 64'(m_hi));
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0; op = 3'b000; src_a = '0; src_b = '0;
      quiet = 1'b1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (done || busy) quiet = 1'b0;
      end
      chk("flush_start_nothing", 64'(quiet), 64'(1));
      @(posedge clk); #1;

      // Reset asserted in cycle 5 of a MULT with nonzero hi/lo.
      mt(OP_MTHI, 32'hAAAA5555);
      mt(OP_MTLO, 32'h5555AAAA);
      issue(OP_MULT, 32'd3, 32'd5);
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b0;
      #1;
      chk("midrst_hi", 64'(hi), 64'(0));
      chk("midrst_lo", 64'(lo), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_stall", 64'(stall_out), 64'(0));
      m_hi = '0; m_lo = '0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      sb_q.push_back(model(OP_MULT, 32'hFFFFFFF0, 32'h00000011, m_hi, m_lo));
      issue(OP_MULT, 32'hFFFFFFF0, 32'h00000011);
      wait_done(1, 34);

      // BPC=4 instance: same MULT, done in cycle WIDTH/4+2.
      start4 = 1'b1; op4 = OP_MULT; a4 = 32'hFFFFFFFF; b4 = 32'h00000002;
      @(negedge clk);
      chk("bpc4_stall_accept", 64'(stall4), 64'(1));
      @(posedge clk); #1;
      start4 = 1'b0; op4 = 3'b000; a4 = '0; b4 = '0;
      lat = 1; seen = 1'b0;
      while (!seen && lat < 100) begin
         @(negedge clk);
         if (done4) seen = 1'b1;
         else begin @(posedge clk); #1; lat++; end
      end
      chk("bpc4_done_seen", 64'(seen), 64'(1));
      chk("bpc4_latency", 64'(lat), 64'(10));
      chk("bpc4_hi", 64'(hi4), 64'(32'hFFFFFFFF));
      chk("bpc4_lo", 64'(lo4), 64'(32'hFFFFFFFE));
      chk("bpc4_div_zero", 64'(dz4), 64'(0));
      chk("bpc4_busy_at_done", 64'(busy4), 64'(0));
      @(posedge clk); #1;

      chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/exe_muldiv.md
EXE_MULDIV -- requirements
Module: exe_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; even, >= 8.
REQ-002 SHALL have parameter BPC, default 1, quotient/multiplier bits processed per cycle; SHALL divide WIDTH exactly; legal values 1, 2, 4.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  in  1  request qualifier for op.
REQ-006 SHALL have port op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 none.
REQ-007 SHALL have port src_a  in  WIDTH  multiplicand/dividend/move data.
REQ-008 SHALL have port src_b  in  WIDTH  multiplier/divisor.
REQ-009 SHALL have port flush  in  1  abort in-flight operation.
REQ-010 SHALL have port stall_out  out  1  pipeline hold request.
REQ-011 SHALL have port busy  out  1  FSM not in IDLE.
REQ-012 SHALL have port done  out  1  one-cycle pulse; hi/lo just updated by mul/div.
REQ-013 SHALL have port div_zero  out  1  one-cycle pulse, divisor was zero.
REQ-014 SHALL have ports hi, lo  out  WIDTH each  result registers.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, FINISH; N = WIDTH/BPC.
REQ-016 IDLE + start + op in 001..100 + !flush: latch operand magnitudes (absolute value for signed ops), result signs, op; load counter with N; go CALC.
REQ-017 CALC: process BPC bits per cycle (shift-add multiply / restoring divide), decrement counter; counter reaching 0 -> FINISH.
REQ-018 FINISH: apply sign correction; at exiting edge write hi/lo, assert done next cycle; -> IDLE.
REQ-019 Latency: start in cycle 0 -> done high and hi/lo valid in cycle N+2.
REQ-020 stall_out SHALL be combinational: high in accepting IDLE cycle, all CALC cycles and FINISH cycle; low when done is high; low whenever flush is high.
REQ-021 MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned.
REQ-022 DIV/DIVU: lo = quotient, hi = remainder; signed quotient truncates toward zero; remainder sign = dividend sign.
REQ-023 Signed most-negative / -1: lo = most-negative value (wrap), hi = 0; no error flag.
REQ-024 Divisor zero: hi/lo unchanged; still full N+2 latency; done and div_zero pulse together.
REQ-025 MTHI/MTLO in IDLE with start: hi (resp. lo) <= src_a at next edge; no stall, no done.
REQ-026 start while busy SHALL be ignored (upstream is held by stall_out).
REQ-027 flush in any state: FSM -> IDLE at next edge, hi/lo unchanged, no done/div_zero pulse; flush and start in same cycle: flush wins, nothing accepted.
REQ-028 busy SHALL be registered state decode (state != IDLE).

Reset
REQ-029 rst low SHALL immediately force state IDLE, counter 0, hi = 0, lo = 0, done = 0, div_zero = 0, busy = 0, stall_out = 0, independent of clk.
REQ-030 Reset asserted mid-operation SHALL discard the operation; no done after release.
REQ-031 First start SHALL be accepted in the first clock cycle after rst deasserts.

Verification (WIDTH=32, BPC=1)
REQ-032 MULT src_a=FFFFFFFF, src_b=00000002 -> cycle 34: done=1, hi=FFFFFFFF, lo=FFFFFFFE; stall_out high cycles 0..33.
REQ-033 MULTU same operands -> hi=00000001, lo=FFFFFFFE.
REQ-034 DIV src_a=FFFFFFF9 (-7), src_b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; DIV 80000000 / FFFFFFFF -> lo=80000000, hi=00000000.
REQ-035 DIVU 00000007 / 00000000 after MTHI 11111111, MTLO 22222222 -> done=1, div_zero=1, hi=11111111, lo=22222222.
REQ-036 DIVU started, flush at cycle 10 -> busy low cycle 11, no done; new MULTU started cycle 12 completes cycle 46 correctly.
REQ-037 rst pulsed low at cycle 5 of MULT with hi/lo nonzero -> hi=lo=0 immediately, no done; BPC=4 run of REQ-032 -> done at cycle 10.
